pim_conv_issuer: RTL and testbench

- Initiator-side sequencer for the 5x5 PIM convolution array.
- Accepts one 25-pixel window per valid/ready handshake and holds it stable on the array's data inputs.
- Walks the PIM word address through N_ADDR kernel slots, pulsing the compute flag once per slot, and waits the array's fixed latency.
- Captures each 18-bit result and presents it downstream with valid/ready and its address tag.

---
 rtl/pim_conv_issuer_if.sv | 39 +++
 rtl/pim_conv_issuer.sv | 135 +++++++++++++
 tb/tb_pim_conv_issuer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pim_conv_issuer_if.sv
// Bundles the window, PIM array and result signals used by pim_conv_issuer.
// The master modport is the sequencer's view. The slave modport is the view
// of the environment around it: window source, PIM array and result sink.
interface pim_conv_issuer_if #(
    parameter int P_IN   = 6,
    parameter int ADDR_W = 5,
    parameter int OUT_W  = 18
);
    // Window intake
    logic                 win_valid;
    logic                 win_ready;
    logic [25*P_IN-1:0]   win_data;

    // PIM array side
    logic [25*P_IN-1:0]   pim_in_data;
    logic [ADDR_W-1:0]    pim_add;
    logic                 pim_compute;
    logic [OUT_W-1:0]     pim_out;

    // Result stream and status
    logic                 res_valid;
    logic                 res_ready;
    logic [OUT_W-1:0]     res_data;
    logic [ADDR_W-1:0]    res_addr;
    logic                 done;
    logic                 busy;

    modport master (
        input  win_valid, win_data, pim_out, res_ready,
        output win_ready, pim_in_data, pim_add, pim_compute,
               res_valid, res_data, res_addr, done, busy
    );

    modport slave (
        output win_valid, win_data, pim_out, res_ready,
        input  win_ready, pim_in_data, pim_add, pim_compute,
               res_valid, res_data, res_addr, done, busy
    );
endinterface

// File: rtl/pim_conv_issuer.sv
// pim_conv_issuer: initiator-side sequencer for the 5x5 PIM convolution array.
// It latches one 25-pixel window and then, for each of N_ADDR kernel slots,
// pulses compute, waits PIM_LAT cycles and captures the result. Each result is
// offered downstream until it is accepted. Only one slot is in flight at a time.
module pim_conv_issuer #(
    parameter int P_IN    = 6,
    parameter int N_ADDR  = 4,
    parameter int ADDR_W  = 5,
    parameter int PIM_LAT = 1,
    parameter int OUT_W   = 18
) (
    input  logic              clk,
    input  logic              rst,
    pim_conv_issuer_if.master bus
);
    localparam int WIN_W = 25 * P_IN;
    localparam int LAT_W = (PIM_LAT < 2) ? 1 : $clog2(PIM_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ADDR - 1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(PIM_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT
    } state_t;

    state_t              state_q;
    logic [WIN_W-1:0]    win_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LAT_W-1:0]    lat_q;
    logic [ADDR_W-1:0]   pim_add_q;
    logic                compute_q;
    logic                res_valid_q;
    logic [OUT_W-1:0]    res_data_q;
    logic [ADDR_W-1:0]   res_addr_q;
    logic                win_ready_q;
    logic                busy_q;

    logic                win_fire;
    logic                res_fire;
    logic                last_slot;
    logic [ADDR_W-1:0]   addr_d;
    logic [LAT_W-1:0]    lat_d;

    assign win_fire  = bus.win_valid && win_ready_q;
    assign res_fire  = res_valid_q && bus.res_ready;
    assign last_slot = (addr_q == LAST_ADDR);
    assign addr_d    = addr_q + ADDR_W'(1);
    assign lat_d     = lat_q - LAT_W'(1);

    // Sequencer FSM. Every output except done is a register. pim_add is loaded
    // on the way into ISSUE so that it is already valid in the compute cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            win_q       <= '0;
            addr_q      <= '0;
            lat_q       <= '0;
            pim_add_q   <= '0;
            compute_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_addr_q  <= '0;
            win_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_fire) begin
                        win_q       <= bus.win_data;
                        addr_q      <= '0;
                        pim_add_q   <= '0;
                        compute_q   <= 1'b1;
                        win_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end else begin
                        win_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                S_ISSUE: begin
                    compute_q <= 1'b0;
                    lat_q     <= LAT_INIT;
                    state_q   <= S_WAIT;
                end

                S_WAIT: begin
                    if (lat_q == LAT_W'(1)) begin
                        res_data_q  <= bus.pim_out;
                        res_addr_q  <= addr_q;
                        res_valid_q <= 1'b1;
                        state_q     <= S_PRESENT;
                    end else begin
                        lat_q <= lat_d;
                    end
                end

                S_PRESENT: begin
                    if (res_fire) begin
                        res_valid_q <= 1'b0;
                        if (last_slot) begin
                            // The next window is accepted no earlier than the following cycle.
                            win_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            addr_q    <= addr_d;
                            pim_add_q <= addr_d;
                            compute_q <= 1'b1;
                            state_q   <= S_ISSUE;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.win_ready   = win_ready_q;
    assign bus.pim_in_data = win_q;
    assign bus.pim_add     = pim_add_q;
    assign bus.pim_compute = compute_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_addr    = res_addr_q;
    assign bus.busy        = busy_q;
    // done marks the accept of the last slot, so it is tied to the handshake itself.
    assign bus.done        = res_fire && last_slot;
endmodule

// File: tb/tb_pim_conv_issuer.sv
// Testbench for pim_conv_issuer. Instance A (N_ADDR=4, PIM_LAT=1) is checked
// every cycle against a transaction-level model, with a behavioural PIM array
// supplying the results. Instance B (N_ADDR=1, PIM_LAT=3) gets a directed run.
module tb_pim_conv_issuer;
    localparam int P_IN   = 6;
    localparam int ADDR_W = 5;
    localparam int OUT_W  = 18;
    localparam int WIN_W  = 25 * P_IN;
    localparam int NA     = 4;
    localparam int LA     = 1;
    localparam int NB     = 1;
    localparam int LB     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pim_conv_issuer_if #(.P_IN(P_IN), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) ifa ();
    pim_conv_issuer_if #(.P_IN(P_IN), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) ifb ();

    pim_conv_issuer #(.P_IN(P_IN), .N_ADDR(NA), .ADDR_W(ADDR_W), .PIM_LAT(LA), .OUT_W(OUT_W))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    pim_conv_issuer #(.P_IN(P_IN), .N_ADDR(NB), .ADDR_W(ADDR_W), .PIM_LAT(LB), .OUT_W(OUT_W))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIN_W-1:0] fill(input logic [P_IN-1:0] p);
        return {25{p}};
    endfunction

    function automatic logic [WIN_W-1:0] rand_win();
        logic [WIN_W-1:0] w;
        for (int i = 0; i < 25; i++) w[i*P_IN +: P_IN] = P_IN'($urandom);
        return w;
    endfunction

    // Result the PIM array returns for a window and slot.
    function automatic logic [OUT_W-1:0] pim_ref(input logic [WIN_W-1:0] w, input int slot, input bit hash);
        int s;
        s = 0;
        for (int i = 0; i < 25; i++) s += int'(w[i*P_IN +: P_IN]);
        return OUT_W'(100 + slot + (hash ? s * 37 : 0));
    endfunction

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] a;
        logic [WIN_W-1:0]  d;
    } pim_req_t;

    pim_req_t          pq[$];
    pim_req_t          cur_req;
    pim_req_t          old_req;
    bit                hash_en   = 1'b0;
    bit                rst_edge  = 1'b1;
    int                cyc       = 0;
    bit                m_idle    = 1'b1;
    int                m_slot    = 0;
    int                m_issue   = -1;
    int                m_present = -1;
    logic [WIN_W-1:0]  m_win     = '0;
    logic [ADDR_W-1:0] m_pa      = '0;
    bit                exp_rv;
    bit                exp_done;
    int                n_res     = 0;
    int                n_done    = 0;

    always @(posedge clk) rst_edge = rst;

    // PIM array model and the per-cycle reference model for instance A.
    always @(negedge clk) begin
        cyc++;
        cur_req.v = ifa.pim_compute;
        cur_req.a = ifa.pim_add;
        cur_req.d = ifa.pim_in_data;
        if (rst) begin
            pq.delete();
            ifa.pim_out = OUT_W'($urandom);
            check_eq("rst_ctl_a", {ifa.win_ready, ifa.pim_compute, ifa.res_valid, ifa.done, ifa.busy}, '0);
            check_eq("rst_bus_a", {ifa.pim_add, ifa.res_addr, ifa.res_data}, '0);
            check_eq("rst_win_a", ifa.pim_in_data, '0);
            m_idle = 1'b1; m_slot = 0; m_issue = -1; m_present = -1; m_win = '0; m_pa = '0;
        end else begin
            // The array answers exactly LA cycles after a compute pulse and returns noise otherwise.
            pq.push_back(cur_req);
            if (pq.size() > LA) old_req = pq.pop_front();
            else old_req = '0;
            ifa.pim_out = old_req.v ? pim_ref(old_req.d, int'(old_req.a), hash_en) : OUT_W'($urandom);

            if (cyc == m_issue) m_pa = ADDR_W'(m_slot);
            exp_rv   = !m_idle && (m_present >= 0) && (cyc >= m_present);
            exp_done = exp_rv && ifa.res_ready && (m_slot == NA - 1);
            check_eq("win_ready", ifa.win_ready, m_idle && !rst_edge);
            check_eq("busy", ifa.busy, !m_idle);
            check_eq("pim_compute", ifa.pim_compute, cyc == m_issue);
            check_eq("pim_add", ifa.pim_add, m_pa);
            check_eq("pim_in_data", ifa.pim_in_data, m_win);
            check_eq("res_valid", ifa.res_valid, exp_rv);
            check_eq("done", ifa.done, exp_done);
            if (exp_rv && ifa.res_valid) begin
                check_eq("res_addr", ifa.res_addr, ADDR_W'(m_slot));
                check_eq("res_data", ifa.res_data, pim_ref(m_win, m_slot, hash_en));
            end

            if (m_idle) begin
                if (!rst_edge && ifa.win_valid) begin
                    m_win = ifa.win_data; m_slot = 0; m_idle = 1'b0;
                    m_issue = cyc + 1; m_present = cyc + 2 + LA;
                end
            end else if (exp_rv && ifa.res_ready) begin
                n_res++;
                if (m_slot == NA - 1) begin
                    m_idle = 1'b1; m_issue = -1; m_present = -1; n_done++;
                end else begin
                    m_slot++; m_issue = cyc + 1; m_present = cyc + 2 + LA;
                end
            end
        end
    end

    task automatic send_win(input logic [WIN_W-1:0] d);
        int t;
        t = 0;
        @(posedge clk); #1;
        ifa.win_valid = 1'b1;
        ifa.win_data  = d;
        do begin @(negedge clk); t++; end while (!ifa.win_ready && t < 100);
        if (!ifa.win_ready) check_eq("accept_timeout", ifa.win_ready, 1'b1);
        @(posedge clk); #1;
        ifa.win_valid = 1'b0;
        ifa.win_data  = rand_win();
    endtask

    task automatic wait_idle_a(input int max_cyc);
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (ifa.busy && t < max_cyc);
        check_eq("drain_a", ifa.busy, 1'b0);
    endtask

    int k;
    int base_res;
    int base_done;

    initial begin
        ifa.win_valid = 1'b0; ifa.win_data = '0; ifa.res_ready = 1'b0;
        ifb.win_valid = 1'b0; ifb.win_data = '0; ifb.res_ready = 1'b0; ifb.pim_out = '0;

        // Reset, then idle
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ctl_b", {ifb.win_ready, ifb.pim_compute, ifb.res_valid, ifb.done, ifb.busy}, '0);
        check_eq("rst_bus_b", {ifb.pim_add, ifb.res_addr, ifb.res_data, ifb.pim_in_data}, '0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_ready_a", ifa.win_ready, 1'b1);
        check_eq("idle_busy_a", ifa.busy, 1'b0);
        check_eq("idle_ready_b", ifb.win_ready, 1'b1);
        check_eq("idle_busy_b", ifb.busy, 1'b0);

        // One window, res_ready always high
        hash_en = 1'b0;
        ifa.res_ready = 1'b1;
        base_res = n_res; base_done = n_done;
        send_win(fill(6'h2A));
        k = 0;
        do begin @(negedge clk); k++; end while (!ifa.res_valid && k < 20);
        check_eq("first_valid_lat", k, 2 + LA);
        wait_idle_a(200);
        check_eq("t2_results", n_res - base_res, NA);
        check_eq("t2_done", n_done - base_done, 1);
        check_eq("t2_win_hold", ifa.pim_in_data, fill(6'h2A));
        check_eq("t2_add_hold", ifa.pim_add, NA - 1);

        // Backpressure at slot 1
        @(posedge clk); #1;
        ifa.res_ready = 1'b0;
        send_win(fill(6'h2A));
        k = 0;
        do begin @(negedge clk); k++; end while (!(ifa.res_valid && ifa.res_addr == 0) && k < 20);
        @(posedge clk); #1 ifa.res_ready = 1'b1;
        @(posedge clk); #1 ifa.res_ready = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!(ifa.res_valid && ifa.res_addr == 1) && k < 20);
        @(posedge clk); #1;
        ifa.win_valid = 1'b1;
        ifa.win_data  = rand_win();
        repeat (10) begin
            @(negedge clk);
            check_eq("stall_valid", ifa.res_valid, 1'b1);
            check_eq("stall_data", ifa.res_data, 101);
            check_eq("stall_addr", ifa.res_addr, 1);
            check_eq("stall_compute", ifa.pim_compute, 1'b0);
            check_eq("stall_win_ready", ifa.win_ready, 1'b0);
        end
        @(posedge clk); #1;
        ifa.win_valid = 1'b0;
        ifa.res_ready = 1'b1;
        wait_idle_a(200);

        // Back-to-back windows with win_valid held high
        @(posedge clk); #1;
        base_res = n_res; base_done = n_done;
        ifa.res_ready = 1'b1;
        ifa.win_valid = 1'b1;
        ifa.win_data  = fill(6'h01);
        k = 0;
        do begin @(negedge clk); k++; end while (!ifa.done && k < 100);
        check_eq("t4_done1", ifa.done, 1'b1);
        @(posedge clk); #1;
        ifa.win_data = fill(6'h3F);
        check_eq("t4_hold_old", ifa.pim_in_data, fill(6'h01));
        @(negedge clk);
        check_eq("t4_ready_gap", ifa.win_ready, 1'b1);
        @(posedge clk); #1;
        check_eq("t4_switch", ifa.pim_in_data, fill(6'h3F));
        check_eq("t4_busy", ifa.busy, 1'b1);
        ifa.win_valid = 1'b0;
        wait_idle_a(200);
        check_eq("t4_results", n_res - base_res, 2 * NA);
        check_eq("t4_done", n_done - base_done, 2);

        // Reset during WAIT of slot 2
        base_done = n_done;
        send_win(rand_win());
        k = 0;
        do begin @(negedge clk); k++; end while (!(ifa.pim_compute && ifa.pim_add == 2) && k < 100);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ctl", {ifa.win_ready, ifa.pim_compute, ifa.res_valid, ifa.done, ifa.busy}, '0);
        check_eq("mid_rst_bus", {ifa.pim_add, ifa.res_addr, ifa.res_data}, '0);
        check_eq("mid_rst_win", ifa.pim_in_data, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("mid_rst_no_done", n_done - base_done, 0);
        hash_en = 1'b1;
        base_res = n_res; base_done = n_done;
        send_win(rand_win());
        wait_idle_a(200);
        check_eq("post_rst_results", n_res - base_res, NA);
        check_eq("post_rst_done", n_done - base_done, 1);

        // Random windows with random backpressure
        for (int w = 0; w < 25; w++) begin
            base_res = n_res;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_win(rand_win());
            k = 0;
            do begin
                @(posedge clk); #1 ifa.res_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk); k++;
            end while (ifa.busy && k < 400);
            check_eq("rand_drain", ifa.busy, 1'b0);
            check_eq("rand_results", n_res - base_res, NA);
        end

        // Instance B: single slot, three-cycle array latency
        @(posedge clk); #1;
        ifb.res_ready = 1'b1;
        ifb.win_valid = 1'b1;
        ifb.win_data  = fill(6'h15);
        @(negedge clk);
        check_eq("b_ready", ifb.win_ready, 1'b1);
        @(posedge clk); #1;
        ifb.win_valid = 1'b0;
        ifb.win_data  = rand_win();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            ifb.pim_out = (c == 1 + LB) ? OUT_W'(12345) : OUT_W'($urandom_range(0, 12000));
            check_eq("b_compute", ifb.pim_compute, c == 1);
            check_eq("b_add", ifb.pim_add, 0);
            check_eq("b_valid", ifb.res_valid, c == 2 + LB);
            check_eq("b_done", ifb.done, c == 2 + LB);
            check_eq("b_busy", ifb.busy, c <= 2 + LB);
            check_eq("b_win_ready", ifb.win_ready, c > 2 + LB);
            if (c == 2 + LB) begin
                check_eq("b_res_data", ifb.res_data, 12345);
                check_eq("b_res_addr", ifb.res_addr, 0);
            end
        end
        check_eq("b_win_hold", ifb.pim_in_data, fill(6'h15));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
